// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_rx_pkg;

    localparam int unsigned DATA_WD_DEF     = 8;
    localparam int unsigned PRESCALE_WD_DEF = 6;
    localparam int unsigned PRESCALE_8      = 8;
    localparam int unsigned PRESCALE_16     = 16;
    localparam int unsigned PRESCALE_32     = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic is_legal_prescale(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-point majority sampler around the bit centre.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned PrescaleWd = PRESCALE_WD_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  rx_i,
    input  logic [PrescaleWd-1:0] prescale_i,
    output logic [PrescaleWd-1:0] edge_cnt_o,
    output logic                  sample_valid_o,
    output logic                  sampled_bit_o
);

    localparam logic [PrescaleWd-1:0] One = PrescaleWd'(1);

    logic [PrescaleWd-1:0] cnt_q, cnt_d;
    logic [PrescaleWd-1:0] half, half_m1, half_p1, last;
    logic                  s0_q, s1_q;

    assign half    = {1'b0, prescale_i[PrescaleWd-1:1]};
    assign half_m1 = half - One;
    assign half_p1 = half + One;
    assign last    = prescale_i - One;

    always_comb begin
        cnt_d = '0;
        if (run_i && (cnt_q != last)) begin
            cnt_d = cnt_q + One;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            s0_q  <= 1'b0;
            s1_q  <= 1'b0;
        end else if (!run_i) begin
            cnt_q <= '0;
            s0_q  <= 1'b0;
            s1_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_q == half_m1) s0_q <= rx_i;
            if (cnt_q == half)    s1_q <= rx_i;
        end
    end

    // Third sample is the live line so the decision is available at P/2+1.
    assign edge_cnt_o     = cnt_q;
    assign sample_valid_o = run_i && (cnt_q == half_p1);
    assign sampled_bit_o  = maj3(s0_q, s1_q, rx_i);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks, output pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WD     = DATA_WD_DEF,
    parameter int unsigned PRESCALE_WD = PRESCALE_WD_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_RX_IN,
    input  logic [PRESCALE_WD-1:0] i_PRESCALE,
    input  logic                   i_PAR_EN,
    input  logic                   i_PAR_TYP,
    output logic [DATA_WD-1:0]     o_P_DATA,
    output logic                   o_DATA_VALID,
    output logic                   o_PAR_ERR,
    output logic                   o_STP_ERR,
    output logic                   o_BUSY
);

    localparam int unsigned              BitCntWd = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [BitCntWd-1:0]      LastBit  = BitCntWd'(DATA_WD - 1);
    localparam logic [BitCntWd-1:0]      BitOne   = BitCntWd'(1);
    localparam logic [PRESCALE_WD-1:0]   PsOne    = PRESCALE_WD'(1);

    rx_state_e              state_q;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    logic [PRESCALE_WD-1:0] prescale_q;
    logic                   par_en_q, par_typ_q, par_err_q;
    logic [BitCntWd-1:0]    bit_cnt_q;
    logic [DATA_WD-1:0]     shift_q;
    logic [PRESCALE_WD-1:0] edge_cnt;
    logic                   sample_valid, sampled_bit;
    logic                   start_det, run, bit_end, exp_par;

    // Sync flops reset low so a line already held low after reset never looks like a start edge.
    assign start_det = (state_q == IDLE) && rx_prev_q && !rx_sync_q;
    assign run       = (state_q != IDLE) || start_det;
    assign bit_end   = (edge_cnt == (prescale_q - PsOne));
    assign exp_par   = par_typ_q ? ~(^shift_q) : ^shift_q;

    uart_rx_sampler #(
        .PrescaleWd(PRESCALE_WD)
    ) u_sampler (
        .clk_i         (i_clk),
        .rst_ni        (i_rst_n),
        .run_i         (run),
        .rx_i          (rx_sync_q),
        .prescale_i    (prescale_q),
        .edge_cnt_o    (edge_cnt),
        .sample_valid_o(sample_valid),
        .sampled_bit_o (sampled_bit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b0;
            rx_sync_q    <= 1'b0;
            rx_prev_q    <= 1'b0;
            prescale_q   <= PRESCALE_WD'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err_q    <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            o_P_DATA     <= '0;
            o_DATA_VALID <= 1'b0;
            o_PAR_ERR    <= 1'b0;
            o_STP_ERR    <= 1'b0;
            o_BUSY       <= 1'b0;
        end else begin
            rx_meta_q    <= i_RX_IN;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            o_DATA_VALID <= 1'b0;
            o_PAR_ERR    <= 1'b0;
            o_STP_ERR    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_det) begin
                        state_q    <= START;
                        o_BUSY     <= 1'b1;
                        prescale_q <= i_PRESCALE;
                        par_en_q   <= i_PAR_EN;
                        par_typ_q  <= i_PAR_TYP;
                        par_err_q  <= 1'b0;
                    end
                end
                START: begin
                    if (sample_valid && sampled_bit) begin
                        state_q <= IDLE;
                        o_BUSY  <= 1'b0;
                    end else if (bit_end) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (sample_valid) shift_q <= {sampled_bit, shift_q[DATA_WD-1:1]};
                    if (bit_end) begin
                        if (bit_cnt_q == LastBit) begin
                            state_q   <= par_en_q ? PARITY : STOP;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitOne;
                        end
                    end
                end
                PARITY: begin
                    if (sample_valid) par_err_q <= (sampled_bit != exp_par);
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    // Leave at the stop midpoint so a following start edge is never missed.
                    if (sample_valid) begin
                        state_q   <= IDLE;
                        o_BUSY    <= 1'b0;
                        o_PAR_ERR <= par_err_q;
                        o_STP_ERR <= !sampled_bit;
                        if (!par_err_q && sampled_bit) begin
                            o_DATA_VALID <= 1'b1;
                            o_P_DATA     <= shift_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct packed {
        logic          v;
        logic          p;
        logic          s;
        logic [DW-1:0] d;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid, par_err, stp_err, busy;

    ev_t           obs_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_good = '0;

    always #5 clk = ~clk;

    uart_rx #(
        .DATA_WD    (DW),
        .PRESCALE_WD(PW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_RX_IN     (rx),
        .i_PRESCALE  (prescale),
        .i_PAR_EN    (par_en),
        .i_PAR_TYP   (par_typ),
        .o_P_DATA    (p_data),
        .o_DATA_VALID(data_valid),
        .o_PAR_ERR   (par_err),
        .o_STP_ERR   (stp_err),
        .o_BUSY      (busy)
    );

    // Every cycle carrying any pulse is logged; a two-cycle pulse shows up as an extra event.
    always @(negedge clk) begin
        if (rst_n && (data_valid || par_err || stp_err))
            obs_q.push_back(ev_t'({data_valid, par_err, stp_err, p_data}));
    end

    task automatic drive(input logic v);
        @(posedge clk);
        #1 rx = v;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1);
    endtask

    // Serialises one frame, one line value per clock, and returns the expected pulse event.
    task automatic send_frame(input logic [DW-1:0] data, input int p, input logic pe,
                              input logic pt, input logic bad_par, input logic stop_bit,
                              input int glitch_bit, input int gofs, input logic scramble,
                              output ev_t exp);
        logic bq[$];
        logic ep, pbit, perr, serr, v;
        int   k;
        ep   = pt ? ~(^data) : ^data;
        pbit = ep ^ bad_par;
        bq.push_back(1'b0);
        for (int i = 0; i < DW; i++) bq.push_back(data[i]);
        if (pe) bq.push_back(pbit);
        bq.push_back(stop_bit);
        prescale = PW'(p);
        par_en   = pe;
        par_typ  = pt;
        for (int b = 0; b < bq.size(); b++) begin
            for (int c = 0; c < p; c++) begin
                @(posedge clk);
                #1 rx = (b == glitch_bit && c == p / 2 + gofs) ? ~bq[b] : bq[b];
                if (scramble && b == 1 && c == 0) begin
                    k        = $urandom_range(0, 2);
                    prescale = PW'(8 << k);
                    par_en   = 1'($urandom_range(0, 1));
                    par_typ  = 1'($urandom_range(0, 1));
                end
                if (b == bq.size() - 1 && c == 1) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_in_stop: got %b want 1", busy);
                    end
                end
                if (b == bq.size() - 1 && c == p / 2 + 3) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL busy_before_drop: got %b want 1", busy);
                    end
                end
                if (b == bq.size() - 1 && c == p / 2 + 4) begin
                    n_cmp++;
                    if (busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL busy_drop_at_mid: got %b want 0", busy);
                    end
                end
            end
        end
        perr = pe && (pbit != ep);
        serr = !stop_bit;
        v    = !perr && !serr;
        if (v) last_good = data;
        exp = {v, perr, serr, last_good};
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({p_data, data_valid, par_err, stp_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: got %h want 0", {p_data, data_valid, par_err, stp_err, busy});
        end
        @(negedge clk) rst_n = 1'b1;
        idle(5);
        n_cmp++;
        if ({p_data, data_valid, par_err, stp_err, busy} !== '0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_after: got %h events %0d want 0",
                     {p_data, data_valid, par_err, stp_err, busy}, obs_q.size());
        end
    endtask

    task automatic test_p8_noparity();
        ev_t exp;
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, exp);
        drive(1'b1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL p8_busy_drop: got %b want 0", busy);
        end
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'hA3) begin
            n_fail++;
            $display("FAIL p8_frame: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_p16_even();
        ev_t exp;
        send_frame(8'hB4, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, 1'b1, exp);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'hB4) begin
            n_fail++;
            $display("FAIL p16_even: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_p32_odd_bad();
        ev_t exp;
        send_frame(8'hD2, 32, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 1'b1, exp);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'hB4) begin
            n_fail++;
            $display("FAIL p32_par_err: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_stop_err();
        ev_t exp;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, exp);
        idle(8);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'hB4) begin
            n_fail++;
            $display("FAIL stop_err: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, exp);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL after_stop_err: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_glitch();
        ev_t exp;
        prescale = PW'(8);
        par_en   = 1'b0;
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        drive(1'b1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_start_busy: got %b want 1", busy);
        end
        idle(6);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject_busy: got %b want 0", busy);
        end
        idle(20);
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_no_pulse: got n=%0d busy %b want 0 0", obs_q.size(), busy);
        end
        obs_q.delete();
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, 0, 1'b0, exp);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL data_glitch: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e0, e1;
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, e0);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, e1);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", obs_q.size());
        end else begin
            n_cmp++;
            if (obs_q[0] !== e0 || obs_q[1] !== e1) begin
                n_fail++;
                $display("FAIL b2b_order: got %h %h want %h %h", obs_q[0], obs_q[1], e0, e1);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        ev_t           exp;
        logic [DW-1:0] pat;
        pat      = 8'h5A;
        prescale = PW'(8);
        par_en   = 1'b0;
        repeat (8) drive(1'b0);
        for (int b = 0; b < 3; b++) repeat (8) drive(pat[b]);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        last_good = '0;
        #1;
        n_cmp++;
        if ({p_data, data_valid, par_err, stp_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_out: got %h want 0", {p_data, data_valid, par_err, stp_err, busy});
        end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(30);
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got n=%0d busy %b want 0 0", obs_q.size(), busy);
        end
        obs_q.delete();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 1'b0, exp);
        idle(4);
        n_cmp++;
        if (obs_q.size() != 1 || obs_q[0] !== exp || p_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL after_reset: got n=%0d data %h want 1 event %h", obs_q.size(), p_data, exp);
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        ev_t           exp;
        int            p, gb;
        logic          pe, pt, bp, sb;
        logic [DW-1:0] d;
        for (int i = 0; i < 24; i++) begin
            p  = 8 << $urandom_range(0, 2);
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            bp = pe && ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            d  = DW'($urandom);
            gb = $urandom_range(0, 1) ? int'($urandom_range(1, 9 + int'(pe))) : -1;
            send_frame(d, p, pe, pt, bp, sb, gb, int'($urandom_range(0, 2)) - 1, 1'b1, exp);
            idle(int'($urandom_range(3, 10)));
            n_cmp++;
            if (obs_q.size() != 1 || obs_q[0] !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: got n=%0d first %h want %h (p=%0d pe=%b pt=%b)",
                         i, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : ev_t'(0), exp, p, pe, pt);
            end
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_p8_noparity();
        test_p16_even();
        test_p32_odd_bad();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
